// File: rtl/mem_arbiter.sv
// Arbitrates the shared single-port memory between the fetch (IF) and load/store (LS) units.
// Defining ARB_RR_EN selects round-robin arbitration; otherwise LS has fixed priority with an IF starvation guard.
module mem_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic [DATA_W-1:0]     ls_wdata,
    input  logic [DATA_W/8-1:0]   ls_wmask,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_W-1:0]     ls_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
        $error("mem_arbiter: MEM_LAT must be within 1..15");
    end
    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_wait
        $error("mem_arbiter: MAX_WAIT must be within 1..15");
    end

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       owner_ls;
    logic       we_q;
    logic       slot;
    logic       resp;
    logic       if_win;
    logic       ls_win;

`ifdef ARB_RR_EN
    logic       rr_ptr;     // 0: IF has priority on the next conflict, 1: LS
`else
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
    logic [3:0] starve;
`endif

    always_comb begin
        slot = rst && ((state == S_IDLE) || (cnt == 4'd0));
`ifdef ARB_RR_EN
        if (if_req && ls_req) begin
            ls_win = rr_ptr;
            if_win = !rr_ptr;
        end else begin
            ls_win = ls_req;
            if_win = if_req;
        end
`else
        if_win = if_req && (!ls_req || (starve == WAIT_MAX));
        ls_win = ls_req && !if_win;
`endif
    end

    assign if_gnt    = slot && if_win;
    assign ls_gnt    = slot && ls_win;
    assign mem_en    = if_gnt || ls_gnt;
    assign mem_we    = ls_gnt && ls_we;
    assign mem_addr  = ls_gnt ? ls_addr : (if_gnt ? if_addr : '0);
    assign mem_wdata = ls_gnt ? ls_wdata : '0;
    assign mem_wmask = ls_gnt ? ls_wmask : '0;

    // The response cycle coincides with the next issue slot, so back-to-back accesses overlap here.
    assign resp      = rst && (state == S_WAIT) && (cnt == 4'd0);
    assign if_rvalid = resp && !owner_ls;
    assign ls_rvalid = resp && owner_ls;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign ls_rdata  = (ls_rvalid && !we_q) ? mem_rdata : '0;
    assign busy      = (state == S_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            owner_ls <= 1'b0;
            we_q     <= 1'b0;
`ifdef ARB_RR_EN
            rr_ptr   <= 1'b0;
`else
            starve   <= 4'd0;
`endif
        end else if (slot) begin
            if (mem_en) begin
                state    <= S_WAIT;
                cnt      <= LAT_M1;
                owner_ls <= ls_gnt;
                we_q     <= mem_we;
`ifdef ARB_RR_EN
                rr_ptr   <= if_gnt;
`endif
            end else begin
                state <= S_IDLE;
            end
`ifndef ARB_RR_EN
            if (!if_req || if_gnt) begin
                starve <= 4'd0;
            end else if (starve != WAIT_MAX) begin
                starve <= starve + 4'd1;
            end
`endif
        end else begin
            cnt <= cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a MEM_LAT=1 instance driven from a vector table, and a MEM_LAT=3 instance
// exercised by hand-written multi-cycle sequences (long latency, back-to-back issue, reset mid-access).
module tb_mem_arbiter;

    localparam logic [63:0] WD = 64'h0123_4567_89AB_CDEF;
    localparam logic [7:0]  WM = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [63:0] mdata(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A_1234, ~a[31:0]};
    endfunction

    // instance A: MEM_LAT = 1
    logic        a_if_req = 0, a_ls_req = 0, a_ls_we = 0;
    logic [63:0] a_if_addr = '0, a_ls_addr = '0, a_ls_wdata = '0;
    logic [7:0]  a_ls_wmask = '0;
    logic        a_if_gnt, a_if_rvalid, a_ls_gnt, a_ls_rvalid, a_mem_en, a_mem_we, a_busy;
    logic [63:0] a_if_rdata, a_ls_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [7:0]  a_mem_wmask;
    logic [63:0] a_pipe = '0;

    // instance B: MEM_LAT = 3
    logic        b_if_req = 0, b_ls_req = 0, b_ls_we = 0;
    logic [63:0] b_if_addr = '0, b_ls_addr = '0, b_ls_wdata = '0;
    logic [7:0]  b_ls_wmask = '0;
    logic        b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid, b_mem_en, b_mem_we, b_busy;
    logic [63:0] b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [7:0]  b_mem_wmask;
    logic [63:0] b_pipe [3] = '{default: '0};

    always @(posedge clk) begin
        a_pipe    <= a_mem_addr;
        b_pipe[0] <= b_mem_addr;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign a_mem_rdata = mdata(a_pipe);
    assign b_mem_rdata = mdata(b_pipe[2]);

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1), .MAX_WAIT(4)) u_a (
        .clk(clk), .rst(rst),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
        .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .ls_req(a_ls_req), .ls_we(a_ls_we), .ls_addr(a_ls_addr), .ls_wdata(a_ls_wdata),
        .ls_wmask(a_ls_wmask), .ls_gnt(a_ls_gnt), .ls_rvalid(a_ls_rvalid), .ls_rdata(a_ls_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_wmask(a_mem_wmask), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(3), .MAX_WAIT(4)) u_b (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata),
        .ls_wmask(b_ls_wmask), .ls_gnt(b_ls_gnt), .ls_rvalid(b_ls_rvalid), .ls_rdata(b_ls_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_wmask(b_mem_wmask), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        ir;
        logic [63:0] ia;
        logic        lr;
        logic        lw;
        logic [63:0] la;
        logic        eig;
        logic        elg;
        logic        eirv;
        logic        elrv;
        logic [63:0] erd;
        logic        ebusy;
    } vec_t;

    vec_t vecs[$];

    // Response expectations for the MEM_LAT=1 instance follow from the previous row's grant.
    logic        p_v = 0, p_ls = 0, p_we = 0;
    logic [63:0] p_addr = '0;

    task automatic step(input logic ir, input logic [63:0] ia, input logic lr, input logic lw,
                        input logic [63:0] la, input logic eig, input logic elg);
        vec_t v;
        v.ir = ir; v.ia = ia; v.lr = lr; v.lw = lw; v.la = la;
        v.eig   = eig;
        v.elg   = elg;
        v.eirv  = p_v && !p_ls;
        v.elrv  = p_v && p_ls;
        v.erd   = (p_v && !p_we) ? mdata(p_addr) : 64'd0;
        v.ebusy = p_v;
        p_v    = eig || elg;
        p_ls   = elg;
        p_we   = elg && lw;
        p_addr = eig ? ia : la;
        vecs.push_back(v);
    endtask

    task automatic b_clear();
        b_if_req = 0; b_if_addr = '0;
        b_ls_req = 0; b_ls_we = 0; b_ls_addr = '0; b_ls_wdata = '0; b_ls_wmask = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic lw;
        vec_t v;

        // outputs held at zero under reset even with requests pending
        a_if_req = 1; a_ls_req = 1; a_ls_addr = 64'h44; a_if_addr = 64'h88;
        #12;
        chk("rst if_gnt", a_if_gnt, 0);
        chk("rst ls_gnt", a_ls_gnt, 0);
        chk("rst mem_en", a_mem_en, 0);
        chk("rst mem_addr", a_mem_addr, 0);
        chk("rst busy", a_busy, 0);
        chk("rst if_rvalid", a_if_rvalid, 0);
        chk("rst ls_rvalid", a_ls_rvalid, 0);
        a_if_req = 0; a_ls_req = 0; a_ls_addr = '0; a_if_addr = '0;
        @(negedge clk);
        rst = 1;

        // IF-only stream, back-to-back
        step(1, 64'h0, 0, 0, 64'h0, 1, 0);
        step(1, 64'h4, 0, 0, 64'h0, 1, 0);
        step(1, 64'h8, 0, 0, 64'h0, 1, 0);
        step(0, 64'h0, 0, 0, 64'h0, 0, 0);
        // idle
        for (int i = 0; i < 5; i++) step(0, 64'h0, 0, 0, 64'h0, 0, 0);
        // LS write then LS read
        step(0, 64'h0, 1, 1, 64'h20, 0, 1);
        step(0, 64'h0, 1, 0, 64'h28, 0, 1);
        step(0, 64'h0, 0, 0, 64'h0, 0, 0);
        step(0, 64'h0, 0, 0, 64'h0, 0, 0);
        // both requesting continuously
        for (int k = 0; k < 11; k++) begin
`ifdef ARB_RR_EN
            lw = (k % 2 == 1);
`else
            lw = (k % 5 != 4);
`endif
            step(1, 64'h40, 1, 0, 64'h80, !lw, lw);
        end
        step(0, 64'h0, 0, 0, 64'h0, 0, 0);
        step(0, 64'h0, 0, 0, 64'h0, 0, 0);
`ifdef ARB_RR_EN
        // single requesters always win; conflicts go to the one not granted last
        step(0, 64'h0, 1, 0, 64'h90, 0, 1);
        step(0, 64'h0, 1, 0, 64'h98, 0, 1);
        step(1, 64'h50, 1, 0, 64'hA0, 1, 0);
        step(1, 64'h54, 1, 0, 64'hA0, 0, 1);
        step(1, 64'h54, 0, 0, 64'h0, 1, 0);
        step(1, 64'h58, 0, 0, 64'h0, 1, 0);
        step(1, 64'h5C, 1, 0, 64'hA8, 0, 1);
`else
        // a slot without if_req clears the starvation count
        for (int k = 0; k < 3; k++) step(1, 64'h50, 1, 0, 64'hA0, 0, 1);
        step(0, 64'h0, 1, 0, 64'hA4, 0, 1);
        for (int k = 0; k < 4; k++) step(1, 64'h50, 1, 0, 64'hA8, 0, 1);
        step(1, 64'h50, 1, 0, 64'hAC, 1, 0);
`endif
        step(0, 64'h0, 0, 0, 64'h0, 0, 0);
        step(0, 64'h0, 0, 0, 64'h0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(posedge clk); #1;
            a_if_req = v.ir; a_if_addr = v.ia;
            a_ls_req = v.lr; a_ls_we = v.lw; a_ls_addr = v.la;
            a_ls_wdata = WD; a_ls_wmask = WM;
            @(negedge clk);
            chk($sformatf("v%0d if_gnt", i), a_if_gnt, v.eig);
            chk($sformatf("v%0d ls_gnt", i), a_ls_gnt, v.elg);
            chk($sformatf("v%0d mem_en", i), a_mem_en, v.eig | v.elg);
            chk($sformatf("v%0d mem_we", i), a_mem_we, v.elg & v.lw);
            chk($sformatf("v%0d mem_addr", i), a_mem_addr, v.eig ? v.ia : (v.elg ? v.la : 64'd0));
            chk($sformatf("v%0d mem_wdata", i), a_mem_wdata, v.elg ? WD : 64'd0);
            chk($sformatf("v%0d mem_wmask", i), a_mem_wmask, v.elg ? WM : 8'd0);
            chk($sformatf("v%0d if_rvalid", i), a_if_rvalid, v.eirv);
            chk($sformatf("v%0d ls_rvalid", i), a_ls_rvalid, v.elrv);
            chk($sformatf("v%0d if_rdata", i), a_if_rdata, v.eirv ? v.erd : 64'd0);
            chk($sformatf("v%0d ls_rdata", i), a_ls_rdata, v.elrv ? v.erd : 64'd0);
            chk($sformatf("v%0d busy", i), a_busy, v.ebusy);
        end
        @(posedge clk); #1;
        a_if_req = 0; a_ls_req = 0; a_ls_we = 0; a_if_addr = '0; a_ls_addr = '0;

        // MEM_LAT=3: LS write, IF read queued behind it and issued in the response cycle
        @(posedge clk); #1;
        b_ls_req = 1; b_ls_we = 1; b_ls_addr = 64'h100; b_ls_wdata = 64'hDEAD; b_ls_wmask = 8'hFF;
        @(negedge clk);
        chk("w3 ls_gnt", b_ls_gnt, 1);
        chk("w3 mem_we", b_mem_we, 1);
        chk("w3 mem_addr", b_mem_addr, 64'h100);
        chk("w3 mem_wdata", b_mem_wdata, 64'hDEAD);
        chk("w3 mem_wmask", b_mem_wmask, 8'hFF);
        chk("w3 busy c0", b_busy, 0);
        @(posedge clk); #1;
        b_clear();
        b_if_req = 1; b_if_addr = 64'h180;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk($sformatf("w3 c%0d mem_en", c), b_mem_en, 0);
            chk($sformatf("w3 c%0d mem_we", c), b_mem_we, 0);
            chk($sformatf("w3 c%0d if_gnt", c), b_if_gnt, 0);
            chk($sformatf("w3 c%0d ls_rvalid", c), b_ls_rvalid, 0);
            chk($sformatf("w3 c%0d busy", c), b_busy, 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("w3 c3 ls_rvalid", b_ls_rvalid, 1);
        chk("w3 c3 ls_rdata", b_ls_rdata, 0);
        chk("w3 c3 if_rvalid", b_if_rvalid, 0);
        chk("w3 c3 busy", b_busy, 1);
        chk("w3 c3 if_gnt", b_if_gnt, 1);
        chk("w3 c3 mem_addr", b_mem_addr, 64'h180);
        chk("w3 c3 mem_we", b_mem_we, 0);
        @(posedge clk); #1;
        b_clear();
        for (int c = 4; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("w3 c%0d if_rvalid", c), b_if_rvalid, 0);
            chk($sformatf("w3 c%0d ls_rvalid", c), b_ls_rvalid, 0);
            chk($sformatf("w3 c%0d busy", c), b_busy, 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("w3 c6 if_rvalid", b_if_rvalid, 1);
        chk("w3 c6 if_rdata", b_if_rdata, mdata(64'h180));
        chk("w3 c6 ls_rvalid", b_ls_rvalid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w3 c7 busy", b_busy, 0);
        chk("w3 c7 if_rvalid", b_if_rvalid, 0);

        // reset asserted one cycle after an IF grant discards the access
        @(posedge clk); #1;
        b_if_req = 1; b_if_addr = 64'h200;
        @(negedge clk);
        chk("rm if_gnt", b_if_gnt, 1);
        @(posedge clk); #1;
        b_if_req = 0;
        #1 rst = 0;
        b_if_req = 1; b_if_addr = 64'h220; b_ls_req = 1; b_ls_addr = 64'h240;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rm r%0d if_gnt", c), b_if_gnt, 0);
            chk($sformatf("rm r%0d ls_gnt", c), b_ls_gnt, 0);
            chk($sformatf("rm r%0d mem_en", c), b_mem_en, 0);
            chk($sformatf("rm r%0d mem_addr", c), b_mem_addr, 0);
            chk($sformatf("rm r%0d if_rvalid", c), b_if_rvalid, 0);
            chk($sformatf("rm r%0d busy", c), b_busy, 0);
        end
        b_clear();
        rst = 1;
        @(posedge clk); #1;
        b_if_req = 1; b_if_addr = 64'h300;
        @(negedge clk);
        chk("rm post if_gnt", b_if_gnt, 1);
        chk("rm post busy", b_busy, 0);
        chk("rm post if_rvalid", b_if_rvalid, 0);
        @(posedge clk); #1;
        b_clear();
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk($sformatf("rm post c%0d if_rvalid", c), b_if_rvalid, 0);
            chk($sformatf("rm post c%0d busy", c), b_busy, 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rm post c3 if_rvalid", b_if_rvalid, 1);
        chk("rm post c3 if_rdata", b_if_rdata, mdata(64'h300));
        chk("rm post c3 ls_rvalid", b_ls_rvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
